esc_speed_sequencer: RTL and testbench

- Soft-start/soft-stop controller that drives the speed ESC's period_reference and pwm_en inputs.
- On start it loads a slow initial period, then ramps the reference toward the commanded target period in fixed steps at a fixed cadence.
- On stop it ramps back to the start period, then switches the motor off.
- Watches encoder A for stalls and latches a fault that kills drive until software clears it.

---
 rtl/esc_speed_sequencer_if.sv | 33 +++
 rtl/esc_speed_sequencer.sv | 137 +++++++++++++
 tb/tb_esc_speed_sequencer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/esc_speed_sequencer_if.sv
// esc_speed_sequencer_if: control/config inputs and status outputs of the ESC soft-start sequencer.
//   master: drives start/stop/fault_clear/encoder_a and the period/step/interval/stall config.
//   slave : the sequencer, drives period_reference/pwm_en/busy/at_target/fault/state.
interface esc_speed_sequencer_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int STATE_WIDTH = 3
);
    logic                   start;
    logic                   stop;
    logic                   fault_clear;
    logic                   encoder_a;
    logic [DATA_WIDTH-1:0]  start_period;
    logic [DATA_WIDTH-1:0]  target_period;
    logic [DATA_WIDTH-1:0]  ramp_step;
    logic [DATA_WIDTH-1:0]  ramp_interval;
    logic [DATA_WIDTH-1:0]  stall_limit;
    logic [DATA_WIDTH-1:0]  period_reference;
    logic                   pwm_en;
    logic                   busy;
    logic                   at_target;
    logic                   fault;
    logic [STATE_WIDTH-1:0] state;
    modport master (
        output start, stop, fault_clear, encoder_a,
        output start_period, target_period, ramp_step, ramp_interval, stall_limit,
        input  period_reference, pwm_en, busy, at_target, fault, state
    );
    modport slave (
        input  start, stop, fault_clear, encoder_a,
        input  start_period, target_period, ramp_step, ramp_interval, stall_limit,
        output period_reference, pwm_en, busy, at_target, fault, state
    );
endinterface

// File: rtl/esc_speed_sequencer.sv
// esc_speed_sequencer: soft-start/soft-stop ramp of the ESC period reference with encoder stall fault.
//   clk, reset (sync, active-high); bus (slave): start/stop/fault_clear/encoder_a and config in,
//   period_reference/pwm_en/busy/at_target/fault/state out, all registered.
module esc_speed_sequencer #(
    parameter int DATA_WIDTH  = 16,
    parameter int STATE_WIDTH = 3
) (
    input logic                  clk,
    input logic                  reset,
    esc_speed_sequencer_if.slave bus
);
    typedef enum logic [STATE_WIDTH-1:0] {
        IDLE      = STATE_WIDTH'(0),
        RAMP_UP   = STATE_WIDTH'(1),
        RUN       = STATE_WIDTH'(2),
        RAMP_DOWN = STATE_WIDTH'(3),
        FAULT     = STATE_WIDTH'(4)
    } state_t;
    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] ref_q, ref_d;
    logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] stall_q, stall_d;
    logic                  pwm_q, pwm_d;
    logic                  busy_q, busy_d;
    logic                  at_q, at_d;
    logic                  fault_q, fault_d;
    logic                  enc_s1_q, enc_s2_q, enc_prev_q;
    logic                  rise, ramping, active, tick, done, stall_hit;
    logic [DATA_WIDTH-1:0] goal, interval_m1, stepped;
    logic [DATA_WIDTH:0]   diff;
    always_comb begin
        rise        = enc_s2_q && !enc_prev_q;
        ramping     = state_q == RAMP_UP || state_q == RAMP_DOWN;
        active      = ramping || state_q == RUN;
        interval_m1 = bus.ramp_interval == '0 ? '0 : bus.ramp_interval - 1'b1;
        tick        = ramping && cnt_q == interval_m1;
        goal        = state_q == RAMP_DOWN ? bus.start_period : bus.target_period;
        // Distance to the goal is one bit wider so the clamp test can never wrap.
        diff        = ref_q >= goal ? {1'b0, ref_q} - {1'b0, goal} : {1'b0, goal} - {1'b0, ref_q};
        done        = diff <= {1'b0, bus.ramp_step};
        stepped     = done ? goal : (ref_q > goal ? ref_q - bus.ramp_step : ref_q + bus.ramp_step);
        stall_hit   = active && bus.stall_limit != '0 && stall_q >= bus.stall_limit;
    end
    always_comb begin
        state_d = state_q;
        ref_d   = ref_q;
        case (state_q)
            IDLE: begin
                if (bus.start && !bus.stop && bus.start_period != '0 && bus.target_period != '0) begin
                    state_d = RAMP_UP;
                    ref_d   = bus.start_period;
                end
            end
            RAMP_UP: begin
                if (stall_hit) begin
                    state_d = FAULT;
                    ref_d   = '0;
                end else if (bus.stop) begin
                    state_d = RAMP_DOWN;
                end else if (tick) begin
                    ref_d   = stepped;
                    state_d = done ? RUN : RAMP_UP;
                end
            end
            RUN: begin
                if (stall_hit) begin
                    state_d = FAULT;
                    ref_d   = '0;
                end else if (bus.stop) begin
                    state_d = RAMP_DOWN;
                end else if (ref_q != bus.target_period) begin
                    state_d = RAMP_UP;
                end
            end
            RAMP_DOWN: begin
                // The final clamped step is shown for one cycle before the motor is switched off.
                if (stall_hit) begin
                    state_d = FAULT;
                    ref_d   = '0;
                end else if (ref_q == bus.start_period) begin
                    state_d = IDLE;
                    ref_d   = '0;
                end else if (tick) begin
                    ref_d = stepped;
                end
            end
            FAULT: begin
                ref_d = '0;
                if (bus.fault_clear && !bus.start) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                ref_d   = '0;
            end
        endcase
        busy_d  = state_d == RAMP_UP || state_d == RUN || state_d == RAMP_DOWN;
        pwm_d   = busy_d;
        fault_d = state_d == FAULT;
        at_d    = state_d == RUN && ref_d == bus.target_period;
        cnt_d   = (state_d != state_q || !ramping || tick) ? '0 : cnt_q + 1'b1;
        stall_d = (rise || !active || (state_d == RAMP_UP && state_q != RAMP_UP)) ? '0 :
                  (&stall_q ? stall_q : stall_q + 1'b1);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ref_q      <= '0;
            cnt_q      <= '0;
            stall_q    <= '0;
            pwm_q      <= 1'b0;
            busy_q     <= 1'b0;
            at_q       <= 1'b0;
            fault_q    <= 1'b0;
            enc_s1_q   <= 1'b0;
            enc_s2_q   <= 1'b0;
            enc_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ref_q      <= ref_d;
            cnt_q      <= cnt_d;
            stall_q    <= stall_d;
            pwm_q      <= pwm_d;
            busy_q     <= busy_d;
            at_q       <= at_d;
            fault_q    <= fault_d;
            enc_s1_q   <= bus.encoder_a;
            enc_s2_q   <= enc_s1_q;
            enc_prev_q <= enc_s2_q;
        end
    end
    assign bus.period_reference = ref_q;
    assign bus.pwm_en           = pwm_q;
    assign bus.busy             = busy_q;
    assign bus.at_target        = at_q;
    assign bus.fault            = fault_q;
    assign bus.state            = state_q;
endmodule

// File: tb/tb_esc_speed_sequencer.sv
// tb_esc_speed_sequencer: directed-vector bench for the ESC soft-start/soft-stop sequencer.
module tb_esc_speed_sequencer;
    logic clk;
    logic reset;
    logic enc_run;
    int   enc_ph;
    int   checks;
    int   failures;
    esc_speed_sequencer_if bus ();
    esc_speed_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    // Encoder A: rising edge every 20 cycles while enc_run, otherwise held low.
    initial begin
        bus.encoder_a = 1'b0;
        enc_ph = 0;
        forever begin
            @(negedge clk);
            enc_ph = enc_run ? (enc_ph == 19 ? 0 : enc_ph + 1) : 0;
            bus.encoder_a = enc_run && enc_ph < 10;
        end
    end
    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic wait_state(input string tag, input int exp, input int max_cycles);
        int n = 0;
        while (32'(bus.state) != exp && n < max_cycles) begin
            cyc();
            n++;
        end
        check(tag, 32'(bus.state), 32'(exp));
    endtask
    initial begin
        int exp450[6] = '{900, 800, 700, 600, 500, 450};
        int n;
        checks = 0;
        failures = 0;
        enc_run = 1'b0;
        reset = 1'b1;
        bus.start = 1'b1;
        bus.stop = 1'b0;
        bus.fault_clear = 1'b0;
        bus.start_period = 16'd1000;
        bus.target_period = 16'd400;
        bus.ramp_step = 16'd100;
        bus.ramp_interval = 16'd4;
        bus.stall_limit = 16'd0;
        repeat (3) cyc();
        check("rst_state", 32'(bus.state), 0);
        check("rst_ref", 32'(bus.period_reference), 0);
        check("rst_pwm", 32'(bus.pwm_en), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_at", 32'(bus.at_target), 0);
        check("rst_fault", 32'(bus.fault), 0);
        reset = 1'b0;
        cyc();
        check("start_state", 32'(bus.state), 1);
        check("start_ref", 32'(bus.period_reference), 1000);
        check("start_pwm", 32'(bus.pwm_en), 1);
        bus.start = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            repeat (3) cyc();
            check("up_hold", 32'(bus.period_reference), 32'(1000 - 100 * (k - 1)));
            cyc();
            check("up_step", 32'(bus.period_reference), 32'(1000 - 100 * k));
        end
        check("run_state", 32'(bus.state), 2);
        check("run_at", 32'(bus.at_target), 1);
        check("run_busy", 32'(bus.busy), 1);
        repeat (5) cyc();
        check("run_hold", 32'(bus.period_reference), 400);
        // soft stop, with start asserted throughout the ramp-down
        bus.stop = 1'b1;
        cyc();
        bus.stop = 1'b0;
        bus.start = 1'b1;
        check("stop_state", 32'(bus.state), 3);
        check("stop_ref", 32'(bus.period_reference), 400);
        for (int k = 1; k <= 6; k++) begin
            repeat (4) cyc();
            check("down_step", 32'(bus.period_reference), 32'(400 + 100 * k));
        end
        check("down_state", 32'(bus.state), 3);
        bus.start = 1'b0;
        cyc();
        check("off_state", 32'(bus.state), 0);
        check("off_ref", 32'(bus.period_reference), 0);
        check("off_pwm", 32'(bus.pwm_en), 0);
        // start together with stop, and start with a zero period, are ignored
        bus.start = 1'b1;
        bus.stop = 1'b1;
        repeat (2) cyc();
        check("start_stop_idle", 32'(bus.state), 0);
        bus.stop = 1'b0;
        bus.start_period = 16'd0;
        repeat (2) cyc();
        check("zero_period_idle", 32'(bus.state), 0);
        bus.start = 1'b0;
        bus.start_period = 16'd1000;
        // non-multiple step clamps at the target
        bus.target_period = 16'd450;
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            repeat (4) cyc();
            check("clamp_step", 32'(bus.period_reference), 32'(exp450[k]));
        end
        check("clamp_run", 32'(bus.state), 2);
        check("clamp_at", 32'(bus.at_target), 1);
        bus.stop = 1'b1;
        cyc();
        bus.stop = 1'b0;
        wait_state("clamp_back_idle", 0, 100);
        // retarget while running, with encoder activity keeping the stall counter low
        bus.target_period = 16'd400;
        bus.stall_limit = 16'd50;
        enc_run = 1'b1;
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        wait_state("retgt_run", 2, 100);
        bus.target_period = 16'd600;
        cyc();
        check("retgt_up", 32'(bus.state), 1);
        check("retgt_at", 32'(bus.at_target), 0);
        repeat (4) cyc();
        check("retgt_500", 32'(bus.period_reference), 500);
        repeat (4) cyc();
        check("retgt_600", 32'(bus.period_reference), 600);
        check("retgt_run2", 32'(bus.state), 2);
        repeat (120) cyc();
        check("enc_no_fault", 32'(bus.fault), 0);
        check("enc_run_state", 32'(bus.state), 2);
        bus.stop = 1'b1;
        cyc();
        bus.stop = 1'b0;
        wait_state("retgt_idle", 0, 100);
        enc_run = 1'b0;
        repeat (10) cyc();
        // stall fault with no encoder edges
        bus.target_period = 16'd400;
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        check("stall_up", 32'(bus.state), 1);
        n = 0;
        while (!bus.fault && n < 200) begin
            cyc();
            n++;
        end
        check("stall_latency", 32'(n), 51);
        check("stall_state", 32'(bus.state), 4);
        check("stall_pwm", 32'(bus.pwm_en), 0);
        check("stall_ref", 32'(bus.period_reference), 0);
        check("stall_busy", 32'(bus.busy), 0);
        bus.fault_clear = 1'b1;
        bus.start = 1'b1;
        repeat (3) cyc();
        check("clear_with_start", 32'(bus.state), 4);
        bus.start = 1'b0;
        cyc();
        check("clear_state", 32'(bus.state), 0);
        check("clear_fault", 32'(bus.fault), 0);
        bus.fault_clear = 1'b0;
        // ramp_interval of 0 behaves as one tick per cycle
        bus.stall_limit = 16'd0;
        bus.ramp_interval = 16'd0;
        bus.target_period = 16'd800;
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        check("iv0_start", 32'(bus.period_reference), 1000);
        cyc();
        check("iv0_900", 32'(bus.period_reference), 900);
        cyc();
        check("iv0_800", 32'(bus.period_reference), 800);
        check("iv0_run", 32'(bus.state), 2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
